// File: rtl/ov7670_dvp_pattern_tx_if.sv
// Camera-side DVP pixel bus: pixel clock, frame/line strobes, byte data and end-of-frame pulse.
interface ov7670_dvp_pattern_tx_if;
   logic       pclk;
   logic       vsync;
   logic       href;
   logic [7:0] data;
   logic       frame_done;

   modport master (output pclk, vsync, href, data, frame_done);
   modport slave  (input  pclk, vsync, href, data, frame_done);
endinterface

// File: rtl/ov7670_dvp_pattern_tx.sv
// OV7670-style DVP transmitter: emits framed RGB444 test patterns (two bytes per pixel)
// so the capture path can be exercised without a sensor.
module ov7670_dvp_pattern_tx #(
   parameter int ACTIVE_COLUMNS = 640,
   parameter int ACTIVE_ROWS    = 480,
   parameter int VSYNC_LINES    = 3,
   parameter int VBP_LINES      = 17,
   parameter int VFP_LINES      = 10,
   parameter int HBLANK_BYTES   = 288,
   parameter int CLK_DIV        = 2
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        enable_i,
   input  logic [1:0]  pattern_sel_i,
   input  logic [11:0] solid_rgb_i,
   ov7670_dvp_pattern_tx_if.master dvp
);
   // state    | meaning
   // S_IDLE   | no frame; pclk free-runs, strobes and data low
   // S_VSYNC  | vsync high for whole lines
   // S_VBP    | blank lines before the first active row
   // S_ACTIVE | pixel rows; href high over the pixel bytes of each line
   // S_VFP    | blank lines after the last row; frame_done on the final cycle

   localparam int ACTIVE_BYTES = 2 * ACTIVE_COLUMNS;
   localparam int LINE_BYTES   = ACTIVE_BYTES + HBLANK_BYTES;
   localparam int MAX_AB       = (ACTIVE_ROWS > VSYNC_LINES) ? ACTIVE_ROWS : VSYNC_LINES;
   localparam int MAX_CD       = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
   localparam int MAX_LINES    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int BAR_PIX      = ACTIVE_COLUMNS / 8;
   localparam int DIV_W        = $clog2(CLK_DIV);
   localparam int BYTE_W       = $clog2(LINE_BYTES);
   localparam int LINE_W       = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
   localparam int BAR_W        = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_VBP,
      S_ACTIVE,
      S_VFP
   } state_t;

   state_t state, state_next;

   logic [DIV_W-1:0]  div_cnt;
   logic [BYTE_W-1:0] byte_cnt;
   logic [LINE_W-1:0] line_cnt;
   logic [LINE_W-1:0] state_last;
   logic [BAR_W-1:0]  bar_pix;
   logic [2:0]        bar_idx;
   logic [1:0]        pat_sel_q;
   logic [11:0]       solid_q;

   logic period_end, line_end, state_end, start_frame, enter_vsync, in_pixels;
   logic [4:0] pix_x, pix_y;
   logic [3:0] pix_r, pix_g, pix_b;

   assign period_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign line_end    = period_end && (byte_cnt == BYTE_W'(LINE_BYTES - 1));
   assign state_end   = line_end && (line_cnt == state_last);
   assign start_frame = (state == S_IDLE) && enable_i;
   assign enter_vsync = (state_next == S_VSYNC) && (state != S_VSYNC);
   assign in_pixels   = (state == S_ACTIVE) && (byte_cnt < BYTE_W'(ACTIVE_BYTES));

   always_comb begin
      state_last = '0;
      case (state)
         S_VSYNC:  state_last = LINE_W'(VSYNC_LINES - 1);
         S_VBP:    state_last = LINE_W'(VBP_LINES - 1);
         S_ACTIVE: state_last = LINE_W'(ACTIVE_ROWS - 1);
         S_VFP:    state_last = LINE_W'(VFP_LINES - 1);
         default:  state_last = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) state <= S_IDLE;
      else           state <= state_next;
   end

   always_comb begin
      state_next     = state;
      dvp.pclk       = (div_cnt >= DIV_W'(CLK_DIV / 2));
      dvp.vsync      = 1'b0;
      dvp.href       = 1'b0;
      dvp.data       = 8'h00;
      dvp.frame_done = 1'b0;
      case (state)
         S_IDLE:   if (enable_i) state_next = S_VSYNC;
         S_VSYNC: begin
            dvp.vsync = 1'b1;
            if (state_end) state_next = S_VBP;
         end
         S_VBP:    if (state_end) state_next = S_ACTIVE;
         S_ACTIVE: begin
            dvp.href = in_pixels;
            if (in_pixels) dvp.data = byte_cnt[0] ? {pix_g, pix_b} : {4'h0, pix_r};
            if (state_end) state_next = S_VFP;
         end
         S_VFP: begin
            dvp.frame_done = state_end;
            if (state_end) state_next = enable_i ? S_VSYNC : S_IDLE;
         end
         default:  state_next = S_IDLE;
      endcase
   end

   // Bar colours fall out of the bar index bits: R=~idx[1], G=~idx[2], B=~idx[0].
   always_comb begin
      pix_x = 5'(byte_cnt >> 1);
      pix_y = 5'(line_cnt);
      pix_r = 4'h0;
      pix_g = 4'h0;
      pix_b = 4'h0;
      case (pat_sel_q)
         2'd0: begin
            pix_r = {4{~bar_idx[1]}};
            pix_g = {4{~bar_idx[2]}};
            pix_b = {4{~bar_idx[0]}};
         end
         2'd1: begin
            pix_r = pix_x[3:0];
            pix_g = pix_y[3:0];
            pix_b = pix_x[3:0] ^ pix_y[3:0];
         end
         2'd2:    {pix_r, pix_g, pix_b} = (pix_x[4] ^ pix_y[4]) ? 12'hFFF : 12'h000;
         default: {pix_r, pix_g, pix_b} = solid_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         div_cnt   <= '0;
         byte_cnt  <= '0;
         line_cnt  <= '0;
         bar_pix   <= '0;
         bar_idx   <= '0;
         pat_sel_q <= 2'd0;
         solid_q   <= 12'h000;
      end else begin
         // Frame start realigns the byte period so the first VSYNC byte is a full period.
         div_cnt <= (start_frame || period_end) ? '0 : div_cnt + 1'b1;

         if (state == S_IDLE) begin
            byte_cnt <= '0;
            line_cnt <= '0;
         end else if (period_end) begin
            byte_cnt <= line_end ? '0 : byte_cnt + 1'b1;
            if (line_end) line_cnt <= state_end ? '0 : line_cnt + 1'b1;
         end

         if (line_end || state != S_ACTIVE) begin
            bar_pix <= '0;
            bar_idx <= '0;
         end else if (in_pixels && period_end && byte_cnt[0]) begin
            if (bar_pix == BAR_W'(BAR_PIX - 1)) begin
               bar_pix <= '0;
               bar_idx <= bar_idx + 1'b1;
            end else begin
               bar_pix <= bar_pix + 1'b1;
            end
         end

         if (enter_vsync) begin
            pat_sel_q <= pattern_sel_i;
            solid_q   <= solid_rgb_i;
         end
      end
   end
endmodule
